// File: rtl/led_pwm_dimmer_core.sv
// rtl/led_pwm_dimmer_core.sv - per-LED PWM dimmer with software-driven duty fades
module led_pwm_dimmer_core #(
  parameter int PRESC_DIV = 390,
  parameter int FADE_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [3:0]  blink_in,
  output logic [3:0]  led_out
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int MW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [MW-1:0] MS_LAST    = MW'(FADE_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  logic [7:0]    r_target [4];
  logic [7:0]    r_duty   [4];
  state_t        r_state  [4];
  logic [7:0]    r_ctrl;
  logic [7:0]    r_step_ms;
  logic [PW-1:0] r_presc_cnt;
  logic [7:0]    r_pwm_cnt;
  logic [MW-1:0] r_ms_cnt;
  logic [7:0]    r_step_cnt;
  logic [3:0]    r_led_out;

  logic          w_wr_en;
  logic          w_pwm_tick;
  logic          w_ms_tick;
  logic          w_step_tick;
  logic [7:0]    w_step_max;
  logic [3:0]    w_fading;
  logic [7:0]    w_duty_nxt  [4];
  state_t        w_state_nxt [4];
  logic          w_unused;

  assign w_unused    = &{1'b0, read, addr[4:3], wr_data[31:8]};
  assign w_wr_en     = cs & write;
  assign w_pwm_tick  = (r_presc_cnt == PRESC_LAST);
  assign w_ms_tick   = (r_ms_cnt == MS_LAST);
  assign w_step_max  = (r_step_ms == 8'd0) ? 8'd1 : r_step_ms;
  // >= rather than == so a STEP_MS shrink below the running count still fires
  assign w_step_tick = w_ms_tick && (({1'b0, r_step_cnt} + 9'd1) >= {1'b0, w_step_max});
  assign led_out     = r_led_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc_cnt <= '0;
      r_pwm_cnt   <= 8'd0;
      r_ms_cnt    <= '0;
      r_step_cnt  <= 8'd0;
    end else begin
      r_presc_cnt <= w_pwm_tick ? '0 : r_presc_cnt + 1'b1;
      if (w_pwm_tick) r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_ms_cnt <= w_ms_tick ? '0 : r_ms_cnt + 1'b1;
      if (w_wr_en && addr[2:0] == 3'd5) r_step_cnt <= 8'd0;
      else if (w_step_tick)             r_step_cnt <= 8'd0;
      else if (w_ms_tick)               r_step_cnt <= r_step_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_target[i] <= 8'd0;
      r_ctrl    <= 8'd0;
      r_step_ms <= 8'd0;
    end else if (w_wr_en) begin
      case (addr[2:0])
        3'd0, 3'd1, 3'd2, 3'd3: r_target[addr[1:0]] <= wr_data[7:0];
        3'd4:                   r_ctrl              <= wr_data[7:0];
        3'd5:                   r_step_ms           <= wr_data[7:0];
        default: ;
      endcase
    end
  end

  // Decisions use the registered target, so a same-clk TARGET write only affects later clks
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_state_nxt[i] = r_state[i];
      w_duty_nxt[i]  = r_duty[i];
      if (!r_ctrl[4+i]) begin
        w_state_nxt[i] = S_IDLE;
        w_duty_nxt[i]  = r_target[i];
      end else begin
        case (r_state[i])
          S_IDLE: begin
            if (r_target[i] > r_duty[i])      w_state_nxt[i] = S_UP;
            else if (r_target[i] < r_duty[i]) w_state_nxt[i] = S_DOWN;
          end
          S_UP: begin
            if (r_target[i] == r_duty[i])     w_state_nxt[i] = S_IDLE;
            else if (r_target[i] < r_duty[i]) w_state_nxt[i] = S_DOWN;
            else if (w_step_tick) begin
              w_duty_nxt[i] = r_duty[i] + 8'd1;
              if (r_duty[i] + 8'd1 == r_target[i]) w_state_nxt[i] = S_IDLE;
            end
          end
          S_DOWN: begin
            if (r_target[i] == r_duty[i])     w_state_nxt[i] = S_IDLE;
            else if (r_target[i] > r_duty[i]) w_state_nxt[i] = S_UP;
            else if (w_step_tick) begin
              w_duty_nxt[i] = r_duty[i] - 8'd1;
              if (r_duty[i] - 8'd1 == r_target[i]) w_state_nxt[i] = S_IDLE;
            end
          end
          default: w_state_nxt[i] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= S_IDLE;
        r_duty[i]  <= 8'd0;
      end
      r_led_out <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_duty[i]    <= w_duty_nxt[i];
        r_led_out[i] <= r_ctrl[i] & blink_in[i] & (r_pwm_cnt < r_duty[i]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) w_fading[i] = (r_state[i] != S_IDLE);
  end

  always_comb begin
    rd_data = 32'd0;
    case (addr[2:0])
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = {16'd0, r_duty[addr[1:0]], r_target[addr[1:0]]};
      3'd4:                   rd_data = {24'd0, r_ctrl};
      3'd5:                   rd_data = {24'd0, r_step_ms};
      3'd6:                   rd_data = {28'd0, w_fading};
      default:                rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_dimmer_core.sv
// tb/tb_led_pwm_dimmer_core.sv - scoreboard bench for led_pwm_dimmer_core
module tb_led_pwm_dimmer_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic [3:0]  blink_in = 4'hF;
  logic [3:0]  led_out;

  led_pwm_dimmer_core #(.PRESC_DIV(1), .FADE_DIV(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .blink_in(blink_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          is_led;
  } exp_t;

  exp_t sb_q[$];
  logic obs_valid = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   chg_t[8];
  int   chg_v[8];
  int   nchg;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (obs_valid) begin
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = e.is_led ? {28'd0, led_out} : rd_data;
        n_checks++;
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d, input logic c = 1'b1);
    cs = c; write = 1'b1; read = 1'b0; addr = {2'b00, a}; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic push_led(input logic [3:0] e, input string n);
    sb_q.push_back('{name: n, exp: {28'd0, e}, is_led: 1'b1});
  endtask

  task automatic expect_rd(input logic [2:0] a, input logic [31:0] e, input string n);
    cs = 1'b1; read = 1'b1; addr = {2'b00, a};
    sb_q.push_back('{name: n, exp: e, is_led: 1'b0});
    obs_valid = 1'b1;
    tick();
    obs_valid = 1'b0; cs = 1'b0; read = 1'b0;
  endtask

  task automatic count_on(input int lane, output int cnt);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (led_out[lane]) cnt++;
    end
    tick();
  endtask

  // Records every duty change of one lane (bench cycle stamp + value) until stop_val or budget
  task automatic watch(input logic [2:0] lane, input int stop_val, input int budget);
    int prev;
    int d;
    cs = 1'b1; read = 1'b1; addr = {2'b00, lane};
    @(negedge clk);
    prev = int'(rd_data[15:8]);
    nchg = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      d = int'(rd_data[15:8]);
      if (d != prev && nchg < 8) begin
        chg_t[nchg] = cyc;
        chg_v[nchg] = d;
        nchg++;
      end
      prev = d;
      if (d == stop_val) break;
    end
    tick();
    cs = 1'b0; read = 1'b0;
  endtask

  initial begin
    int cnt;
    int t1, t2;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    for (int a = 0; a < 7; a++) expect_rd(3'(a), 32'd0, $sformatf("reset_reg%0d", a));
    push_led(4'h0, "reset_led");
    expect_rd(3'd4, 32'd0, "reset_ctrl");

    reg_write(3'd1, 32'h55, 1'b0);
    reg_write(3'd6, 32'hFF);
    reg_write(3'd7, 32'hFF);
    expect_rd(3'd1, 32'd0, "cs0_write_ignored");
    expect_rd(3'd6, 32'd0, "status_write_ignored");
    expect_rd(3'd7, 32'd0, "addr7_write_ignored");

    blink_in = 4'h1;
    reg_write(3'd4, 32'h0F);
    reg_write(3'd0, 32'd64);
    repeat (3) tick();
    expect_rd(3'd0, 32'h0000_4040, "duty_snap_64");
    count_on(0, cnt);
    check("pwm_duty64", cnt, 64);
    reg_write(3'd0, 32'd255);
    repeat (3) tick();
    count_on(0, cnt);
    check("pwm_duty255", cnt, 255);
    reg_write(3'd0, 32'd0);
    repeat (3) tick();
    count_on(0, cnt);
    check("pwm_duty0", cnt, 0);
    reg_write(3'd0, 32'd64);
    reg_write(3'd4, 32'h0E);
    repeat (3) tick();
    count_on(0, cnt);
    check("led_en_off", cnt, 0);
    reg_write(3'd4, 32'h0F);
    blink_in = 4'h0;
    repeat (3) tick();
    count_on(0, cnt);
    check("blink_low", cnt, 0);
    blink_in = 4'h1;

    reg_write(3'd0, 32'd0);
    repeat (2) tick();
    reg_write(3'd5, 32'd2);
    reg_write(3'd4, 32'h11);
    expect_rd(3'd5, 32'd2, "step_ms_rd");
    expect_rd(3'd4, 32'h11, "ctrl_rd");
    reg_write(3'd0, 32'd3);
    watch(3'd0, 2, 40);
    check("fade_up_nchg_a", nchg, 2);
    check("fade_up_v1", chg_v[0], 1);
    check("fade_up_v2", chg_v[1], 2);
    t1 = chg_t[0];
    t2 = chg_t[1];
    check("fade_up_gap12", t2 - t1, 8);
    expect_rd(3'd6, 32'd1, "status_fading");
    watch(3'd0, 3, 40);
    check("fade_up_v3", chg_v[0], 3);
    check("fade_up_gap23", chg_t[0] - t2, 8);
    expect_rd(3'd6, 32'd0, "status_done");
    expect_rd(3'd0, 32'h0000_0303, "fade_up_final");

    reg_write(3'd4, 32'h01);
    reg_write(3'd0, 32'd0);
    repeat (2) tick();
    reg_write(3'd4, 32'h11);
    reg_write(3'd0, 32'd10);
    watch(3'd0, 2, 40);
    check("refade_reach2", chg_v[1], 2);
    reg_write(3'd0, 32'd0);
    watch(3'd0, 0, 40);
    check("retarget_nchg", nchg, 2);
    check("retarget_v1", chg_v[0], 1);
    check("retarget_v0", chg_v[1], 0);
    check("retarget_gap", chg_t[1] - chg_t[0], 8);
    expect_rd(3'd6, 32'd0, "status_after_down");

    reg_write(3'd0, 32'd200);
    repeat (3) tick();
    expect_rd(3'd6, 32'd1, "status_mid_fade");
    reg_write(3'd4, 32'h01);
    tick();
    expect_rd(3'd0, {16'd0, 8'd200, 8'd200}, "fade_off_snap");
    expect_rd(3'd6, 32'd0, "fade_off_status");

    blink_in = 4'h2;
    reg_write(3'd4, 32'h02);
    reg_write(3'd1, 32'd5);
    repeat (2) tick();
    reg_write(3'd4, 32'h22);
    reg_write(3'd1, 32'd20);
    repeat (2) tick();
    expect_rd(3'd6, 32'd2, "status1_fading");
    reset = 1'b0;
    push_led(4'h0, "reset_led_async");
    expect_rd(3'd1, 32'd0, "reset_duty1_async");
    for (int a = 0; a < 7; a++) expect_rd(3'(a), 32'd0, $sformatf("inreset_reg%0d", a));
    reset = 1'b1;
    repeat (2) tick();
    expect_rd(3'd1, 32'd0, "post_reset_reg1");
    expect_rd(3'd6, 32'd0, "post_reset_status");

    tick();
    check("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
